// File: rtl/permute_feeder_pkg.sv
// Shared constants for the bf16 permute feeder: FSM encoding, default geometry
// and small elaboration-time helpers.
package permute_feeder_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_NUMSTAGES = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILL    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    function automatic int beats_f(input int numstages, input int in_lanes);
        return numstages / in_lanes;
    endfunction

    // Counter width that stays at least one bit when the count is 1.
    function automatic int cnt_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/permute_feeder_pack.sv
// Lane-to-row pack buffer: collects IN_LANES elements per accepted beat and
// flags the beat that completes a row, presenting the full row combinationally.
module permute_feeder_pack
    import permute_feeder_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUMSTAGES = DEF_NUMSTAGES,
    parameter int IN_LANES  = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          beat_en,
    input  logic [IN_LANES*WIDTH-1:0]     in_data,
    output logic                          row_full,
    output logic [NUMSTAGES*WIDTH-1:0]    row_data
);

    localparam int BEATS = beats_f(NUMSTAGES, IN_LANES);
    localparam int CW    = cnt_w_f(BEATS);
    localparam int BW    = IN_LANES * WIDTH;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [CW-1:0]              beat_cnt_r;
    logic [NUMSTAGES*WIDTH-1:0] pack_buf_r;
    logic                       beat_last_s;

    assign beat_last_s = (beat_cnt_r == LAST_BEAT);
    assign row_full    = beat_en && beat_last_s;

    // Row view including the beat being accepted this cycle.
    always_comb begin
        row_data = pack_buf_r;
        row_data[int'(beat_cnt_r)*BW +: BW] = in_data;
    end

    // Beat counter and pack buffer update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_cnt_r <= {CW{1'b0}};
            pack_buf_r <= {(NUMSTAGES*WIDTH){1'b0}};
        end else if (beat_en) begin
            pack_buf_r[int'(beat_cnt_r)*BW +: BW] <= in_data;
            beat_cnt_r <= beat_last_s ? {CW{1'b0}} : beat_cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/permute_feeder.sv
// Upstream feeder of the bf16 matrix permute unit: packs lane beats into rows,
// issues them as load pulses and holds off the next matrix until busy cycles.
module permute_feeder
    import permute_feeder_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int NUMSTAGES    = DEF_NUMSTAGES,
    parameter int LOGNUMSTAGES = $clog2(NUMSTAGES),
    parameter int IN_LANES     = 2
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic                               cfg_row_col_op,
    input  logic [NUMSTAGES*LOGNUMSTAGES-1:0]  cfg_row_num,
    input  logic [NUMSTAGES*LOGNUMSTAGES-1:0]  cfg_col_num,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_LANES*WIDTH-1:0]          in_data,
    input  logic                               in_last,
    output logic                               perm_en,
    output logic [NUMSTAGES*WIDTH-1:0]         perm_row,
    output logic                               perm_rw_col_op,
    output logic [NUMSTAGES*LOGNUMSTAGES-1:0]  perm_row_num,
    output logic [NUMSTAGES*LOGNUMSTAGES-1:0]  perm_col_num,
    input  logic                               perm_busy,
    output logic                               err_last
);

    localparam int SELW = NUMSTAGES * LOGNUMSTAGES;
    localparam int RW   = NUMSTAGES * WIDTH;
    localparam int RCW  = $clog2(NUMSTAGES + 1);
    localparam logic [RCW-1:0] ROWS_ALL  = RCW'(NUMSTAGES);
    localparam logic [RCW-1:0] ROWS_LAST = RCW'(NUMSTAGES - 1);

    logic [1:0]     state_r;
    logic [1:0]     state_nx_s;
    logic [RW-1:0]  row_q_r;
    logic           row_valid_r;
    logic [RCW-1:0] rows_packed_r;
    logic [RCW-1:0] rows_sent_r;
    logic           err_last_r;
    logic           beat_acc_s;
    logic           row_full_s;
    logic [RW-1:0]  row_data_s;
    logic           final_beat_s;

    assign cfg_ready    = (state_r == ST_IDLE);
    assign in_ready     = (state_r == ST_FILL) && (rows_packed_r < ROWS_ALL);
    assign beat_acc_s   = in_valid && in_ready;
    assign final_beat_s = row_full_s && (rows_packed_r == ROWS_LAST);
    // row_valid_r is only ever set in FILL and is drained before FILL exits.
    assign perm_en      = row_valid_r;
    assign perm_row     = row_q_r;
    assign err_last     = err_last_r;

    permute_feeder_pack #(
        .WIDTH     (WIDTH),
        .NUMSTAGES (NUMSTAGES),
        .IN_LANES  (IN_LANES)
    ) u_pack (
        .clk      (clk),
        .resetn   (resetn),
        .beat_en  (beat_acc_s),
        .in_data  (in_data),
        .row_full (row_full_s),
        .row_data (row_data_s)
    );

    // Next-state logic for the matrix handshake FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_valid) state_nx_s = ST_FILL;
                else           state_nx_s = ST_IDLE;
            end
            ST_FILL: begin
                if (row_valid_r && (rows_sent_r == ROWS_LAST)) state_nx_s = ST_WAIT_HI;
                else                                          state_nx_s = ST_FILL;
            end
            ST_WAIT_HI: begin
                if (perm_busy) state_nx_s = ST_WAIT_LO;
                else           state_nx_s = ST_WAIT_HI;
            end
            ST_WAIT_LO: begin
                if (!perm_busy) state_nx_s = ST_IDLE;
                else            state_nx_s = ST_WAIT_LO;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_r <= ST_IDLE;
        else         state_r <= state_nx_s;
    end

    // Config latch, row staging, row counters and sticky framing error.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perm_rw_col_op <= 1'b0;
            perm_row_num   <= {SELW{1'b0}};
            perm_col_num   <= {SELW{1'b0}};
            row_q_r        <= {RW{1'b0}};
            row_valid_r    <= 1'b0;
            rows_packed_r  <= {RCW{1'b0}};
            rows_sent_r    <= {RCW{1'b0}};
            err_last_r     <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && cfg_valid) begin
                perm_rw_col_op <= cfg_row_col_op;
                perm_row_num   <= cfg_row_num;
                perm_col_num   <= cfg_col_num;
                rows_packed_r  <= {RCW{1'b0}};
                rows_sent_r    <= {RCW{1'b0}};
            end else begin
                if (row_full_s) begin
                    row_q_r       <= row_data_s;
                    rows_packed_r <= rows_packed_r + RCW'(1);
                end
                if (row_valid_r) rows_sent_r <= rows_sent_r + RCW'(1);
            end
            // A staged row is sent every cycle it is valid, so it survives only if refilled.
            row_valid_r <= row_full_s;
            if (beat_acc_s && (in_last != final_beat_s)) err_last_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_permute_feeder.sv
// Scoreboard bench for permute_feeder: a 2-lane instance runs the matrix scenarios,
// an 8-lane instance checks full-rate row issue.
module tb_permute_feeder;

    typedef struct {
        logic [127:0] row;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   pulses2 = 0;
    int   pulses8 = 0;
    exp_t q2[$];
    exp_t q8[$];
    exp_t e2, e8;
    logic [127:0] acc2 = '0;

    logic         cfg_valid = 1'b0, cfg_ready, cfg_row_col_op = 1'b0;
    logic [23:0]  cfg_row_num = '0, cfg_col_num = '0;
    logic         in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [31:0]  in_data = '0;
    logic         perm_en, perm_rw_col_op, perm_busy = 1'b0, err_last;
    logic [127:0] perm_row;
    logic [23:0]  perm_row_num, perm_col_num;

    logic         cfg_valid_8 = 1'b0, cfg_ready_8;
    logic         in_valid_8 = 1'b0, in_ready_8, in_last_8 = 1'b0;
    logic [127:0] in_data_8 = '0;
    logic         perm_en_8, perm_rw_col_op_8, perm_busy_8 = 1'b0, err_last_8;
    logic [127:0] perm_row_8;
    logic [23:0]  perm_row_num_8, perm_col_num_8;

    logic [23:0]  rn_fwd, rn_rev;

    permute_feeder #(.IN_LANES(2)) dut (
        .clk(clk), .resetn(resetn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_row_col_op(cfg_row_col_op),
        .cfg_row_num(cfg_row_num), .cfg_col_num(cfg_col_num),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .perm_en(perm_en), .perm_row(perm_row), .perm_rw_col_op(perm_rw_col_op),
        .perm_row_num(perm_row_num), .perm_col_num(perm_col_num),
        .perm_busy(perm_busy), .err_last(err_last)
    );

    permute_feeder #(.IN_LANES(8)) dut8 (
        .clk(clk), .resetn(resetn),
        .cfg_valid(cfg_valid_8), .cfg_ready(cfg_ready_8), .cfg_row_col_op(1'b1),
        .cfg_row_num(rn_fwd), .cfg_col_num(rn_rev),
        .in_valid(in_valid_8), .in_ready(in_ready_8), .in_data(in_data_8), .in_last(in_last_8),
        .perm_en(perm_en_8), .perm_row(perm_row_8), .perm_rw_col_op(perm_rw_col_op_8),
        .perm_row_num(perm_row_num_8), .perm_col_num(perm_col_num_8),
        .perm_busy(perm_busy_8), .err_last(err_last_8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop for both instances on every load pulse.
    always @(negedge clk) begin
        if (resetn && perm_en) begin
            pulses2++;
            if (q2.size() == 0) check_val("spurious_en2", 1, 0);
            else begin
                e2 = q2.pop_front();
                check_val("row2", perm_row, e2.row);
                check_val("lat2", cyc, e2.cyc);
            end
        end
        if (resetn && perm_en_8) begin
            pulses8++;
            if (q8.size() == 0) check_val("spurious_en8", 1, 0);
            else begin
                e8 = q8.pop_front();
                check_val("row8", perm_row_8, e8.row);
                check_val("lat8", cyc, e8.cyc);
            end
        end
    end

    task automatic do_cfg(input logic op, input logic [23:0] rn, input logic [23:0] cn);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_row_col_op = op; cfg_row_num = rn; cfg_col_num = cn;
        for (int i = 0; i < 20 && !cfg_ready; i++) @(negedge clk);
        check_val("cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_row_col_op = ~op; cfg_row_num = ~rn; cfg_col_num = ~cn;
        check_val("cfg_op", perm_rw_col_op, op);
        check_val("cfg_row_num", perm_row_num, rn);
        check_val("cfg_col_num", perm_col_num, cn);
    endtask

    // Beats are numbered 1..32 within a matrix; element k of beat b is base+2(b-1)+k.
    task automatic send2(input logic [15:0] base, input int first, input int n, input int gap, input int last_at);
        for (int b = first; b < first + n; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = {base + 16'(2*b - 1), base + 16'(2*b - 2)};
            in_last  = (b == last_at);
            for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
            if (!in_ready) check_val("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
            in_valid = 1'b0; in_last = 1'b0;
            for (int l = 0; l < 2; l++) begin
                int e = 2*(b-1) + l;
                acc2[(e % 8)*16 +: 16] = base + 16'(e);
                if (e % 8 == 7) q2.push_back('{acc2, cyc});
            end
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send8(input logic [15:0] base, input int n);
        for (int b = 1; b <= n; b++) begin
            logic [127:0] r;
            for (int l = 0; l < 8; l++) r[l*16 +: 16] = base + 16'(8*(b-1) + l);
            @(negedge clk);
            in_valid_8 = 1'b1; in_data_8 = r; in_last_8 = (b == n);
            for (int i = 0; i < 100 && !in_ready_8; i++) @(negedge clk);
            if (!in_ready_8) check_val("in_ready8_timeout", 0, 1);
            @(posedge clk); #1;
            in_valid_8 = 1'b0; in_last_8 = 1'b0;
            q8.push_back('{r, cyc});
        end
    endtask

    task automatic drain(input int pulses_before);
        for (int i = 0; i < 100 && q2.size() != 0; i++) @(negedge clk);
        check_val("drain_rows_left", q2.size(), 0);
        @(negedge clk);
        check_val("pulse_count", pulses2 - pulses_before, 8);
        check_val("in_ready_after", in_ready, 0);
    endtask

    task automatic finish2();
        @(negedge clk); perm_busy = 1'b1;
        repeat (2) @(negedge clk);
        perm_busy = 1'b0;
        for (int i = 0; i < 10 && !cfg_ready; i++) @(negedge clk);
        check_val("back_to_idle", cfg_ready, 1);
    endtask

    initial begin
        int p0;
        for (int i = 0; i < 8; i++) begin
            rn_fwd[i*3 +: 3] = 3'(i);
            rn_rev[i*3 +: 3] = 3'(7 - i);
        end
        repeat (3) @(negedge clk);
        check_val("rst_perm_en", perm_en, 0);
        check_val("rst_perm_row", perm_row, 0);
        check_val("rst_cfg", {perm_rw_col_op, perm_row_num, perm_col_num}, 0);
        check_val("rst_err", err_last, 0);
        check_val("rst_in_ready", in_ready, 0);
        resetn = 1'b1;
        @(negedge clk);
        check_val("idle_cfg_ready", cfg_ready, 1);

        // Basic matrix
        do_cfg(1'b1, rn_fwd, rn_fwd);
        p0 = pulses2;
        send2(16'h3F80, 1, 32, 0, 32);
        drain(p0);
        check_val("basic_err", err_last, 0);

        // Busy gating with a new config offered while waiting
        cfg_valid = 1'b1; cfg_row_col_op = 1'b0; cfg_row_num = rn_rev; cfg_col_num = rn_fwd;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("gate_lo_cfg_ready", cfg_ready, 0);
            check_val("gate_lo_in_ready", in_ready, 0);
            check_val("gate_cfg_held", perm_row_num, rn_fwd);
        end
        perm_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("gate_hi_cfg_ready", cfg_ready, 0);
            check_val("gate_hi_in_ready", in_ready, 0);
        end
        perm_busy = 1'b0;
        check_val("gate_fall_cfg_ready", cfg_ready, 0);
        @(negedge clk);
        check_val("gate_after_cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check_val("gate_new_op", perm_rw_col_op, 0);
        check_val("gate_new_row_num", perm_row_num, rn_rev);

        // Backpressure gaps
        p0 = pulses2;
        send2(16'h4000, 1, 32, 1, 32);
        drain(p0);
        check_val("gap_err", err_last, 0);
        finish2();

        // Framing error on beat 10
        do_cfg(1'b1, rn_fwd, rn_rev);
        p0 = pulses2;
        send2(16'h4100, 1, 9, 0, 10);
        check_val("frame_err_before", err_last, 0);
        send2(16'h4100, 10, 1, 0, 10);
        @(negedge clk);
        check_val("frame_err_set", err_last, 1);
        send2(16'h4100, 11, 22, 0, 10);
        drain(p0);
        check_val("frame_err_hold", err_last, 1);
        finish2();
        check_val("frame_err_sticky", err_last, 1);

        // Reset mid-fill
        do_cfg(1'b0, rn_rev, rn_rev);
        send2(16'h4200, 1, 13, 0, 32);
        repeat (3) @(negedge clk);
        check_val("midfill_rows_issued", q2.size(), 0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_val("midfill_rst_err", err_last, 0);
        check_val("midfill_rst_cfg", perm_row_num, 0);
        resetn = 1'b1;
        q2.delete();
        acc2 = '0;
        do_cfg(1'b1, rn_fwd, rn_fwd);
        p0 = pulses2;
        send2(16'h5000, 1, 32, 0, 32);
        drain(p0);
        check_val("midfill_err", err_last, 0);

        // 8-lane build: one row per beat, full rate
        @(negedge clk);
        cfg_valid_8 = 1'b1;
        @(posedge clk); #1;
        cfg_valid_8 = 1'b0;
        check_val("cfg8_row_num", perm_row_num_8, rn_fwd);
        p0 = pulses8;
        send8(16'h6000, 8);
        for (int i = 0; i < 50 && q8.size() != 0; i++) @(negedge clk);
        check_val("drain8_rows_left", q8.size(), 0);
        @(negedge clk);
        check_val("pulse_count8", pulses8 - p0, 8);
        check_val("err8", err_last_8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/permute_feeder.md
Name: permute_feeder

Overview:
- Upstream stage of the bfloat16 matrix permute unit.
- Accepts a valid/ready stream of IN_LANES bf16 elements per beat from the vector lane datapath and packs the elements into full NUMSTAGES-element rows.
- Issues the rows to the permute unit as single-cycle load pulses, presenting the latched row/column permute configuration alongside.
- Blocks the next matrix until the permute unit's busy indication has risen and then fallen.

Parameters:
- WIDTH, 16, element width in bits (bf16).
- NUMSTAGES, 8, elements per row and rows per matrix.
- LOGNUMSTAGES, $clog2(NUMSTAGES), width of one row/col select field.
- IN_LANES, 2, elements per input beat; must divide NUMSTAGES. Localparam BEATS = NUMSTAGES/IN_LANES.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  permute configuration offered.
- cfg_ready  out  1  configuration accepted (high only in IDLE).
- cfg_row_col_op  in  1  1 = row op, 0 = column op.
- cfg_row_num  in  NUMSTAGES*LOGNUMSTAGES  row select vector.
- cfg_col_num  in  NUMSTAGES*LOGNUMSTAGES  column select vector.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted.
- in_data  in  IN_LANES*WIDTH  lane 0 in the LSBs.
- in_last  in  1  marks the final beat of a matrix.
- perm_en  out  1  row load pulse to the permute unit.
- perm_row  out  NUMSTAGES*WIDTH  packed row; element 0 in the LSBs.
- perm_rw_col_op  out  1  latched cfg_row_col_op.
- perm_row_num  out  NUMSTAGES*LOGNUMSTAGES  latched cfg_row_num.
- perm_col_num  out  NUMSTAGES*LOGNUMSTAGES  latched cfg_col_num.
- perm_busy  in  1  busy flag from the permute unit.
- err_last  out  1  sticky framing error.

Behaviour:
- Reset (resetn=0 at a clk edge, including mid-matrix):
  - state = IDLE; pack buffer, row_q, row_valid, beat_cnt, rows_packed and rows_sent = 0.
  - perm_en = 0, perm_row = 0, perm_* config = 0, err_last = 0.
  - Any partial row or matrix is discarded.
- FSM states: IDLE, FILL, WAIT_HI, WAIT_LO.
  - IDLE: cfg_ready = 1. On cfg_valid, latch the config into perm_* and go to FILL. perm_* holds until the next IDLE.
  - FILL: in_ready = (rows_packed < NUMSTAGES). On each accepted beat, write in_data into the pack buffer at elements beat_cnt*IN_LANES .. beat_cnt*IN_LANES+IN_LANES-1, then increment beat_cnt.
  - FILL, beat_cnt wraps at BEATS-1: the full row (including the current beat) is copied to row_q, row_valid is set, rows_packed is incremented and beat_cnt returns to 0.
  - FILL, row issue: perm_en = row_valid (registered). Each cycle row_valid=1, row_q is consumed: rows_sent is incremented and row_valid clears, unless a new row is loaded in the same cycle. Simultaneous load and send is legal, so BEATS=1 runs at full rate.
  - Latency: last beat of a row accepted at cycle t → perm_en=1 with that row on perm_row at t+1.
  - FILL exits to WAIT_HI when rows_sent reaches NUMSTAGES, i.e. after the cycle carrying the 8th perm_en.
  - WAIT_HI: wait for perm_busy=1 → WAIT_LO.
  - WAIT_LO: wait for perm_busy=0 → IDLE.
- in_ready = 0 outside FILL and once NUMSTAGES rows are packed.
- Framing check: err_last sets if in_last=1 on an accepted beat that is not the final one (beat NUMSTAGES*BEATS), or if in_last=0 on the final beat.
  - err_last is cleared only by reset.
  - Packing remains count-driven; the matrix proceeds regardless of framing errors.
- cfg_valid outside IDLE is ignored (cfg_ready=0). Config changes after the handshake have no effect.
- perm_en is never asserted outside FILL.

Decomposition:
- Shared package: state encoding (IDLE/FILL/WAIT_HI/WAIT_LO), the BEATS localparam function, and the default WIDTH/NUMSTAGES constants shared with the permute unit.
- One natural sub-module: permute_feeder_pack. It holds the lane-to-row pack buffer, beat_cnt, and the row-complete strobe. The top level keeps the FSM, row_q, counters and the error flag.

Test Plan:
- Basic matrix:
  - Stimulus: reset; cfg row_col_op=1, row_num=col_num={7,6,5,4,3,2,1,0}; 32 back-to-back beats with element k = 16'h3F80+k, in_last on beat 32.
  - Response: 8 perm_en pulses. Row r, element e = 16'h3F80+8r+e. First pulse arrives one cycle after beat 4. err_last stays 0.
- Busy gating:
  - Stimulus: after the 8th pulse, hold perm_busy 0 for 3 cycles, then 1 for 10 cycles, then 0; offer a new cfg.
  - Response: cfg_ready=0 until one cycle after perm_busy falls; in_ready=0 throughout.
- Backpressure gaps:
  - Stimulus: in_valid toggles every other cycle.
  - Response: same 8 rows in order; no perm_en without a completed row.
- Framing error:
  - Stimulus: in_last asserted on beat 10.
  - Response: err_last=1 from the next cycle; all 8 rows are still issued; err_last stays 1 until reset.
- Reset mid-fill:
  - Stimulus: resetn low after 13 beats, then a new full matrix.
  - Response: no stale data; the first new row equals the new beats 1-4 only.
- IN_LANES=8 build:
  - Stimulus: 8 consecutive beats.
  - Response: perm_en high for 8 consecutive cycles, starting one cycle after beat 1.
